// File: rtl/booth_pkg.sv
// Shared types and defaults for the Booth multiplier arbiter.
package booth_pkg;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_W       = 8;
  localparam int DEF_TIMEOUT = 64;

  // Width of a counter that reaches TIMEOUT-1, kept at least one bit.
  function automatic int wd_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

  localparam int WD_W = wd_width(DEF_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    START,
    OPA,
    OPB,
    WAIT,
    LO,
    RESP,
    ABORT
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or above the pointer,
// wrapping around. Purely combinational.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IW-1:0]    o_idx
);

  logic [IW:0] w_pos;
  logic        w_found;

  // Scan upward from the pointer and take the first asserted request.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    w_pos   = '0;
    w_found = 1'b0;
    o_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_pos = {1'b0, i_ptr} + (IW+1)'(k);
      if (w_pos >= (IW+1)'(N_REQ)) w_pos = w_pos - (IW+1)'(N_REQ);
      if (!w_found && i_req[w_pos[IW-1:0]]) begin
        w_found = 1'b1;
        o_idx   = w_pos[IW-1:0];
      end
    end
    o_gnt = w_found ? (N_REQ'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Shares one sequential Booth multiplier among N_REQ requesters: grants
// round-robin, streams the latched operands to the multiplier, collects the
// two-beat product and returns it with a one-cycle ack (err on abort).
module booth_mul_arbiter
  import booth_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int W       = DEF_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] a_in,
  input  logic [N_REQ*W-1:0] b_in,
  output logic [N_REQ-1:0]   ack,
  output logic [2*W-1:0]     res,
  output logic               err,
  output logic               busy,
  output logic               mul_start,
  output logic [W-1:0]       mul_in,
  output logic               mul_clr,
  input  logic               mul_done,
  input  logic [W-1:0]       mul_out
);

  localparam int IW  = $clog2(N_REQ);
  localparam int WDW = wd_width(TIMEOUT);

  state_t           r_state, w_next;
  logic [IW-1:0]    r_ptr, r_gnt;
  logic [W-1:0]     r_a, r_b, r_hi, r_lo;
  logic [WDW-1:0]   r_wd;

  logic [N_REQ-1:0] r_ack, w_ack;
  logic [2*W-1:0]   r_res, w_res;
  logic             r_err, w_err;
  logic             r_busy, w_busy;
  logic             r_start, w_start;
  logic [W-1:0]     r_mul_in, w_mul_in;
  logic             r_clr, w_clr;

  logic [N_REQ-1:0] w_req_eff;
  logic [N_REQ-1:0] w_gnt;
  logic [IW-1:0]    w_idx;
  logic             w_grant;

  // A requester still holding req during its own ack cycle is finishing the
  // old request, not starting a new one.
  assign w_req_eff = req & ~r_ack;
  assign w_grant   = (r_state == IDLE) && (w_gnt != '0);

  rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
    .i_req (w_req_eff),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  // Next-state and next-output decode from the current state.
  always_comb begin
    w_next   = r_state;
    w_ack    = '0;
    w_res    = '0;
    w_err    = 1'b0;
    w_start  = 1'b0;
    w_mul_in = '0;
    w_clr    = 1'b0;
    unique case (r_state)
      IDLE:  if (w_gnt != '0) w_next = START;
      START: begin
        w_start = 1'b1;
        w_next  = OPA;
      end
      OPA: begin
        w_mul_in = r_a;
        w_next   = OPB;
      end
      OPB: begin
        w_mul_in = r_b;
        w_next   = WAIT;
      end
      WAIT: begin
        if (mul_done)                        w_next = LO;
        else if (r_wd == WDW'(TIMEOUT - 1))  w_next = ABORT;
      end
      LO:    w_next = mul_done ? RESP : ABORT;
      RESP: begin
        w_ack  = N_REQ'(1) << r_gnt;
        w_res  = {r_hi, r_lo};
        w_next = IDLE;
      end
      ABORT: begin
        w_ack  = N_REQ'(1) << r_gnt;
        w_err  = 1'b1;
        w_clr  = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    w_busy = (w_next != IDLE);
  end

  // State register, round-robin pointer and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_ack    <= '0;
      r_res    <= '0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_start  <= 1'b0;
      r_mul_in <= '0;
      r_clr    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_ack    <= w_ack;
      r_res    <= w_res;
      r_err    <= w_err;
      r_busy   <= w_busy;
      r_start  <= w_start;
      r_mul_in <= w_mul_in;
      r_clr    <= w_clr;
      if (r_state == RESP || r_state == ABORT)
        r_ptr <= (r_gnt == IW'(N_REQ - 1)) ? '0 : r_gnt + 1'b1;
    end
  end

  // Operand latches, result capture and WAIT watchdog.
  // NOTE: these datapath registers are always written before they are read, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_gnt <= w_idx;
      r_a   <= a_in[w_idx*W +: W];
      r_b   <= b_in[w_idx*W +: W];
    end
    if (r_state == OPB) r_wd <= '0;
    if (r_state == WAIT) begin
      if (mul_done) r_hi <= mul_out;
      else          r_wd <= r_wd + 1'b1;
    end
    if (r_state == LO) r_lo <= mul_out;
  end

  assign ack       = r_ack;
  assign res       = r_res;
  assign err       = r_err;
  assign busy      = r_busy;
  assign mul_start = r_start;
  assign mul_in    = r_mul_in;
  assign mul_clr   = ~rst | r_clr;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Scoreboard bench for booth_mul_arbiter with a behavioural two-beat
// multiplier standing in for the real Booth controller and datapath.
module tb_booth_mul_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 64;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_in, b_in;
  logic [N-1:0]   ack;
  logic [2*W-1:0] res;
  logic           err, busy, mul_start, mul_clr, mul_done;
  logic [W-1:0]   mul_in, mul_out;

  typedef struct packed {
    logic [N-1:0]   ack;
    logic [2*W-1:0] res;
    logic           err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  // Requester levels: raised toggles on issue, acked toggles on ack.
  logic [N-1:0] raised = '0;
  logic [N-1:0] acked  = '0;
  assign req = raised ^ acked;

  // Multiplier model controls and state.
  int                    lat  = 0;
  bit                    tie0 = 1'b0;
  int                    mst  = 0;
  int                    cnt  = 0;
  logic [W-1:0]          cap_x = '0, cap_y = '0;
  logic signed [2*W-1:0] prod = '0;

  booth_mul_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .ack       (ack),
    .res       (res),
    .err       (err),
    .busy      (busy),
    .mul_start (mul_start),
    .mul_in    (mul_in),
    .mul_clr   (mul_clr),
    .mul_done  (mul_done),
    .mul_out   (mul_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural multiplier: start, X beat, Y beat, lat cycles, hi then lo with done.
  initial begin
    mul_done = 1'b0;
    mul_out  = '0;
  end
  always @(negedge clk) begin
    if (mul_clr) begin
      mst      = 0;
      mul_done = 1'b0;
      mul_out  = '0;
    end else begin
      case (mst)
        0: if (mul_start) mst = 1;
        1: begin cap_x = mul_in; mst = 2; end
        2: begin
          cap_y = mul_in;
          prod  = $signed(cap_x) * $signed(cap_y);
          cnt   = lat;
          mst   = 3;
        end
        4: begin mul_out = prod[W-1:0]; mst = 5; end
        5: begin mul_done = 1'b0; mul_out = '0; mst = 0; end
        default: ;
      endcase
      if (mst == 3 && !tie0) begin
        if (cnt == 0) begin
          mul_done = 1'b1;
          mul_out  = prod[2*W-1:W];
          mst      = 4;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Monitor: every ack pops the oldest expectation and compares.
  always @(negedge clk) begin
    if (ack != '0) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_ack: got ack=%b expected none", ack);
      end else begin
        mon_e = sb_q.pop_front();
        check("ack", 32'(ack), 32'(mon_e.ack));
        check("res", 32'(res), 32'(mon_e.res));
        check("err", 32'(err), 32'(mon_e.err));
        check("clr_with_ack", 32'(mul_clr), 32'(mon_e.err));
      end
      acked = acked ^ (ack & req);
    end
  end

  task automatic raise(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
    raised[i]      = ~raised[i];
  endtask

  task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] r, input logic e);
    exp_t x;
    x.ack = N'(1) << i;
    x.res = r;
    x.err = e;
    sb_q.push_back(x);
    raise(i, a, b);
  endtask

  task automatic drain(input int max_cycles);
    for (int k = 0; k < max_cycles; k++) begin
      @(negedge clk);
      #1;
      if (sb_q.size() == 0) return;
    end
    n_checks++;
    n_errors++;
    $display("FAIL drain_timeout: %0d acks outstanding, expected 0", sb_q.size());
    sb_q.delete();
  endtask

  task automatic do_reset();
    rst    = 1'b0;
    raised = acked;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst  = 1'b0;
    a_in = '0;
    b_in = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 0);
    check("reset_ack", 32'(ack), 0);
    check("reset_clr", 32'(mul_clr), 1);
    check("reset_mul_in", 32'(mul_in), 0);
    rst = 1'b1;
    @(negedge clk);

    // Single request, requester 0: 3*5, grant-to-ack is 5 + 1 WAIT cycle.
    issue(0, 8'd3, 8'd5, 16'h000F, 1'b0);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (ack != '0) break;
    end
    check("t1_latency", 32'(n), 7);
    drain(50);
    check("t1_mul_x", 32'(cap_x), 3);
    check("t1_mul_y", 32'(cap_y), 5);
    @(negedge clk);

    // Signed operands, requester 2: -3*7.
    issue(2, 8'hFD, 8'h07, 16'hFFEB, 1'b0);
    drain(50);
    @(negedge clk);

    // All four from reset: served 0,1,2,3.
    do_reset();
    issue(0, 8'd2,  8'd9,  16'h0012, 1'b0);
    issue(1, 8'hFF, 8'hFF, 16'h0001, 1'b0);
    issue(2, 8'h7F, 8'h80, 16'hC080, 1'b0);
    issue(3, 8'd10, 8'hFB, 16'hFFCE, 1'b0);
    drain(200);
    @(negedge clk);
    // Pointer back at 0: req0 and req1 together serve 0 then 1.
    issue(0, 8'd4,  8'd4,  16'h0010, 1'b0);
    issue(1, 8'h80, 8'h80, 16'h4000, 1'b0);
    drain(100);
    @(negedge clk);

    // Operands change in the cycle after grant; latched values are used.
    issue(1, 8'd9, 8'd3, 16'h001B, 1'b0);
    @(posedge clk);
    @(negedge clk);
    a_in[1*W +: W] = 8'h55;
    b_in[1*W +: W] = 8'h66;
    drain(50);
    check("t4_mul_x", 32'(cap_x), 9);
    check("t4_mul_y", 32'(cap_y), 3);
    @(negedge clk);

    // mul_done stuck low: abort with err, then a normal operation.
    tie0 = 1'b1;
    issue(3, 8'd5, 8'd5, 16'h0000, 1'b1);
    drain(TO + 40);
    @(negedge clk);
    check("t5_clr_one_cycle", 32'(mul_clr), 0);
    check("t5_err_one_cycle", 32'(err), 0);
    tie0 = 1'b0;
    issue(0, 8'd11, 8'd12, 16'h0084, 1'b0);
    drain(50);
    @(negedge clk);

    // Reset during WAIT: no ack, multiplier cleared, then 6*7 completes.
    lat = 30;
    raise(2, 8'd1, 8'd1);
    repeat (8) @(negedge clk);
    check("t6_busy_in_wait", 32'(busy), 1);
    rst    = 1'b0;
    raised = acked;
    @(negedge clk);
    check("t6_busy_after_rst", 32'(busy), 0);
    check("t6_ack_after_rst", 32'(ack), 0);
    check("t6_clr_during_rst", 32'(mul_clr), 1);
    rst = 1'b1;
    lat = 0;
    repeat (2) @(negedge clk);
    issue(0, 8'd6, 8'd7, 16'h002A, 1'b0);
    drain(50);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
